// File: rtl/gpio_link_pkg.sv
// rtl/gpio_link_pkg.sv - shared image geometry and readback FSM state type for the Pi GPIO link
// READBACK_CHECKSUM_EN adds the trailing checksum state.
package gpio_link_pkg;

   localparam int DEF_HEIGHT = 20;
   localparam int DEF_WIDTH  = 30;
   localparam int DEF_DEPTH  = 3;
   localparam int IMG_BYTES  = DEF_HEIGHT * DEF_WIDTH * DEF_DEPTH;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_LOAD    = 3'd2,
      S_PRESENT = 3'd3,
`ifdef READBACK_CHECKSUM_EN
      S_CSUM    = 3'd5,
`endif
      S_DONE    = 3'd4
   } rb_state_t;

endpackage

// File: rtl/image_readback_if.sv
// rtl/image_readback_if.sv - control, image-store read port and Pi GPIO byte port of the readback engine
interface image_readback_if #(parameter int ADDR_W = 11);

   logic              start;
   logic              read_enable;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rd_data;
   logic [7:0]        gpio_out;
   logic              byte_valid;
   logic              busy;
   logic              done;
   logic              underrun;

   modport master (
      input  start, read_enable, mem_rd_data,
      output mem_rd_en, mem_addr, gpio_out, byte_valid, busy, done, underrun
   );

   modport slave (
      output start, read_enable, mem_rd_data,
      input  mem_rd_en, mem_addr, gpio_out, byte_valid, busy, done, underrun
   );

endinterface

// File: rtl/gpio_strobe_edge.sv
// rtl/gpio_strobe_edge.sv - rising-edge detector on a Pi strobe, one pulse per low-to-high transition
module gpio_strobe_edge (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic strobe
);

   logic level_prev;

   always_ff @(posedge clk) begin
      if (rst) level_prev <= 1'b0;
      else     level_prev <= level;
   end

   assign strobe = level & ~level_prev;

endmodule

// File: rtl/image_readback.sv
// rtl/image_readback.sv - streams the stored image back to the Pi one byte per read strobe
// Define READBACK_CHECKSUM_EN to append a mod-256 sum byte after the image.
module image_readback
   import gpio_link_pkg::*;
#(
   parameter int HEIGHT = DEF_HEIGHT,
   parameter int WIDTH  = DEF_WIDTH,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = 11
) (
   input  logic             pi_clk,
   input  logic             rst,
   image_readback_if.master bus
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(HEIGHT * WIDTH * DEPTH - 1);

   rb_state_t         state, state_nx;
   logic [ADDR_W-1:0] count;
   logic [7:0]        gpio_q;
   logic              valid_q;
   logic              underrun_q;
   logic              strobe;
   logic              accept_start;
   logic              at_last;
   logic              rd_en_c, busy_c, done_c;
`ifdef READBACK_CHECKSUM_EN
   logic [7:0]        sum_q;
`endif

   gpio_strobe_edge u_edge (
      .clk    (pi_clk),
      .rst    (rst),
      .level  (bus.read_enable),
      .strobe (strobe)
   );

   assign at_last      = (count == LAST_ADDR);
   assign accept_start = bus.start && (state == S_IDLE || state == S_DONE);

   always_ff @(posedge pi_clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      rd_en_c  = 1'b0;
      busy_c   = 1'b0;
      done_c   = 1'b0;
      case (state)
         S_IDLE:    if (bus.start) state_nx = S_FETCH;
         S_FETCH: begin
            rd_en_c  = 1'b1;
            busy_c   = 1'b1;
            state_nx = S_LOAD;
         end
         S_LOAD: begin
            busy_c   = 1'b1;
            state_nx = S_PRESENT;
         end
         S_PRESENT: begin
            busy_c = 1'b1;
            if (strobe) begin
`ifdef READBACK_CHECKSUM_EN
               state_nx = at_last ? S_CSUM : S_FETCH;
`else
               state_nx = at_last ? S_DONE : S_FETCH;
`endif
            end
         end
`ifdef READBACK_CHECKSUM_EN
         S_CSUM: begin
            busy_c = 1'b1;
            if (strobe) state_nx = S_DONE;
         end
`endif
         S_DONE: begin
            done_c = 1'b1;
            if (bus.start) state_nx = S_FETCH;
         end
         default:   state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge pi_clk) begin
      if (rst) begin
         count      <= '0;
         gpio_q     <= '0;
         valid_q    <= 1'b0;
         underrun_q <= 1'b0;
`ifdef READBACK_CHECKSUM_EN
         sum_q      <= '0;
`endif
      end else begin
         if (accept_start) begin
            count      <= '0;
            underrun_q <= 1'b0;
`ifdef READBACK_CHECKSUM_EN
            sum_q      <= '0;
`endif
         end
         if (state == S_LOAD) begin
            gpio_q  <= bus.mem_rd_data;
            valid_q <= 1'b1;
`ifdef READBACK_CHECKSUM_EN
            sum_q   <= sum_q + bus.mem_rd_data;
`endif
         end
         if (state == S_PRESENT && strobe) begin
            valid_q <= 1'b0;
            if (!at_last) count <= count + 1'b1;
`ifdef READBACK_CHECKSUM_EN
            // The checksum byte follows the last image byte with no fetch gap.
            if (at_last) begin
               gpio_q  <= sum_q;
               valid_q <= 1'b1;
            end
`endif
         end
`ifdef READBACK_CHECKSUM_EN
         if (state == S_CSUM && strobe) valid_q <= 1'b0;
`endif
         // A strobe with nothing presented is latched even if a start lands in the same cycle.
         if (strobe && (state == S_IDLE || state == S_FETCH ||
                        state == S_LOAD || state == S_DONE))
            underrun_q <= 1'b1;
      end
   end

   assign bus.mem_rd_en  = rd_en_c;
   assign bus.mem_addr   = count;
   assign bus.gpio_out   = gpio_q;
   assign bus.byte_valid = valid_q;
   assign bus.busy       = busy_c;
   assign bus.done       = done_c;
   assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_image_readback.sv
// tb/tb_image_readback.sv - directed self-checking bench for image_readback against a mem[a]=a^5A store
module tb_image_readback;

   localparam int N = 20 * 30 * 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   int   rd_cnt = 0;
   int   mark;
   logic [7:0] sum_exp;
   logic [7:0] exp_b;

   image_readback_if #(.ADDR_W(11)) bus ();

   image_readback #(.HEIGHT(20), .WIDTH(30), .DEPTH(3), .ADDR_W(11)) dut (
      .pi_clk (clk),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.mem_rd_en) begin
         bus.mem_rd_data <= bus.mem_addr[7:0] ^ 8'h5A;
         rd_cnt <= rd_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic wait_valid();
      for (int t = 0; t < 12 && bus.byte_valid !== 1'b1; t++) @(negedge clk);
   endtask

   task automatic strobe_once();
      bus.read_enable = 1'b1;
      @(negedge clk);
      bus.read_enable = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_rd_en"},    32'(bus.mem_rd_en),  0);
      chk({tag, "_addr"},     32'(bus.mem_addr),   0);
      chk({tag, "_gpio"},     32'(bus.gpio_out),   0);
      chk({tag, "_valid"},    32'(bus.byte_valid), 0);
      chk({tag, "_busy"},     32'(bus.busy),       0);
      chk({tag, "_done"},     32'(bus.done),       0);
      chk({tag, "_underrun"}, 32'(bus.underrun),   0);
   endtask

   initial begin
      bus.start       = 1'b0;
      bus.read_enable = 1'b0;
      bus.mem_rd_data = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("reset");

      // Strobe with nothing presented
      strobe_once();
      chk("idle_underrun", 32'(bus.underrun), 1);
      chk("idle_no_rd", 32'(rd_cnt), 0);

      // Start, no strobes: first byte after three cycles, held
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("fetch_rd_en", 32'(bus.mem_rd_en), 1);
      chk("fetch_busy", 32'(bus.busy), 1);
      chk("start_clears_underrun", 32'(bus.underrun), 0);
      chk("fetch_valid", 32'(bus.byte_valid), 0);
      @(negedge clk);
      chk("load_valid", 32'(bus.byte_valid), 0);
      @(negedge clk);
      chk("first_valid", 32'(bus.byte_valid), 1);
      chk("first_byte", 32'(bus.gpio_out), 32'h5A);
      repeat (100) @(negedge clk);
      chk("hold_valid", 32'(bus.byte_valid), 1);
      chk("hold_byte", 32'(bus.gpio_out), 32'h5A);
      chk("hold_busy", 32'(bus.busy), 1);
      chk("hold_rd_once", 32'(rd_cnt), 1);

      // read_enable held high consumes one byte only
      bus.read_enable = 1'b1;
      @(negedge clk);
      chk("held_gap", 32'(bus.byte_valid), 0);
      repeat (2) @(negedge clk);
      chk("held_next_valid", 32'(bus.byte_valid), 1);
      chk("held_next_byte", 32'(bus.gpio_out), 32'h5B);
      repeat (17) @(negedge clk);
      chk("held_still_valid", 32'(bus.byte_valid), 1);
      chk("held_rd_cnt", 32'(rd_cnt), 2);
      bus.read_enable = 1'b0;
      @(negedge clk);

      // Full stream from a fresh reset
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      sum_exp = 8'h00;
      for (int i = 0; i < N; i++) begin
         wait_valid();
         exp_b = i[7:0] ^ 8'h5A;
         sum_exp = sum_exp + exp_b;
         chk("stream_valid", 32'(bus.byte_valid), 1);
         chk("stream_byte", 32'(bus.gpio_out), 32'(exp_b));
         strobe_once();
      end
`ifdef READBACK_CHECKSUM_EN
      wait_valid();
      chk("csum_valid", 32'(bus.byte_valid), 1);
      chk("csum_not_done", 32'(bus.done), 0);
      chk("csum_busy", 32'(bus.busy), 1);
      chk("csum_byte", 32'(bus.gpio_out), 32'(sum_exp));
      strobe_once();
`endif
      repeat (2) @(negedge clk);
      chk("end_done", 32'(bus.done), 1);
      chk("end_busy", 32'(bus.busy), 0);
      chk("end_valid", 32'(bus.byte_valid), 0);
      chk("end_underrun", 32'(bus.underrun), 0);
`ifdef READBACK_CHECKSUM_EN
      chk("end_hold", 32'(bus.gpio_out), 32'(sum_exp));
`else
      chk("end_hold", 32'(bus.gpio_out), 32'h5D);
`endif

      // Restart from DONE, reset after 500 bytes
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("restart_done_cleared", 32'(bus.done), 0);
      chk("restart_addr", 32'(bus.mem_addr), 0);
      for (int i = 0; i < 500; i++) begin
         wait_valid();
         exp_b = i[7:0] ^ 8'h5A;
         chk("part_byte", 32'(bus.gpio_out), 32'(exp_b));
         strobe_once();
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_all_zero("midrst");
      mark = rd_cnt;
      repeat (5) @(negedge clk);
      chk("midrst_no_rd", 32'(rd_cnt), 32'(mark));
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("midrst_fetch_addr", 32'(bus.mem_addr), 0);
      chk("midrst_fetch_rd", 32'(bus.mem_rd_en), 1);
      wait_valid();
      chk("midrst_first_valid", 32'(bus.byte_valid), 1);
      chk("midrst_first_byte", 32'(bus.gpio_out), 32'h5A);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
